// File: rtl/pipeline_mult_hs.sv
// Pipelined WIDTH x WIDTH integer multiplier with valid/ready handshakes.
// Each stage accumulates |x| times one CW-bit chunk of |y|; the last stage also applies the sign.
module pipeline_mult_hs #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned STAGES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  input  logic                 in_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   prod
);

  localparam int unsigned CW = WIDTH / STAGES;
  localparam int unsigned PW = 2 * WIDTH;

  logic             stall;
  logic [WIDTH-1:0] mag_x, mag_y;
  logic             neg_in;
  logic [PW-1:0]    fsum;

  // Index 0 is the capture register set; index k holds the state after k chunk steps.
  logic             vld [STAGES];
  logic             neg [STAGES];
  logic [WIDTH-1:0] ax  [STAGES];
  logic [WIDTH-1:0] ay  [STAGES];
  logic [PW-1:0]    acc [STAGES];

  function automatic logic [PW-1:0] ppart(input logic [WIDTH-1:0] a,
                                          input logic [WIDTH-1:0] b,
                                          input int unsigned      k);
    logic [CW-1:0] chunk;
    chunk = b[k*CW +: CW];
    return (PW'(a) * PW'(chunk)) << (k*CW);
  endfunction

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  always_comb begin
    mag_x  = (in_signed & x[WIDTH-1]) ? -x : x;
    mag_y  = (in_signed & y[WIDTH-1]) ? -y : y;
    neg_in = in_signed & (x[WIDTH-1] ^ y[WIDTH-1]);
    fsum   = acc[STAGES-1] + ppart(ax[STAGES-1], ay[STAGES-1], STAGES-1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        vld[k] <= 1'b0;
        neg[k] <= 1'b0;
        ax[k]  <= '0;
        ay[k]  <= '0;
        acc[k] <= '0;
      end
      out_valid <= 1'b0;
      prod      <= '0;
    end else if (!stall) begin
      vld[0] <= in_valid;
      neg[0] <= neg_in;
      ax[0]  <= mag_x;
      ay[0]  <= mag_y;
      acc[0] <= '0;
      for (int unsigned k = 1; k < STAGES; k++) begin
        vld[k] <= vld[k-1];
        neg[k] <= neg[k-1];
        ax[k]  <= ax[k-1];
        ay[k]  <= ay[k-1];
        acc[k] <= acc[k-1] + ppart(ax[k-1], ay[k-1], k-1);
      end
      out_valid <= vld[STAGES-1];
      // The final chunk step and sign fix-up share the output register to keep latency at STAGES.
      if (vld[STAGES-1]) prod <= neg[STAGES-1] ? -fsum : fsum;
    end
  end

endmodule

// File: tb/tb_pipeline_mult_hs.sv
// Directed bench for pipeline_mult_hs at 64/4, 16/1 and 32/8 (WIDTH/STAGES).
module tb_pipeline_mult_hs;

  localparam int NV       = 10;
  localparam int WID [3]  = '{64, 16, 32};
  localparam int LAT [3]  = '{4, 1, 8};

  logic clk = 1'b0;
  logic rst_n;
  logic inv  [3];
  logic outr [3];
  logic sg   [3];
  logic [63:0] xs [3];
  logic [63:0] ys [3];
  logic ir [3];
  logic pv [3];
  logic [127:0] p0;
  logic [31:0]  p1;
  logic [63:0]  p2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0]  x;
    logic [63:0]  y;
    logic         s;
    logic [127:0] e;
  } vec_t;
  vec_t tbl [NV];

  always #5 clk = ~clk;

  pipeline_mult_hs #(.WIDTH(64), .STAGES(4)) u_d0 (
    .clk(clk), .reset(rst_n), .in_valid(inv[0]), .in_ready(ir[0]),
    .x(xs[0]), .y(ys[0]), .in_signed(sg[0]),
    .out_valid(pv[0]), .out_ready(outr[0]), .prod(p0));

  pipeline_mult_hs #(.WIDTH(16), .STAGES(1)) u_d1 (
    .clk(clk), .reset(rst_n), .in_valid(inv[1]), .in_ready(ir[1]),
    .x(xs[1][15:0]), .y(ys[1][15:0]), .in_signed(sg[1]),
    .out_valid(pv[1]), .out_ready(outr[1]), .prod(p1));

  pipeline_mult_hs #(.WIDTH(32), .STAGES(8)) u_d2 (
    .clk(clk), .reset(rst_n), .in_valid(inv[2]), .in_ready(ir[2]),
    .x(xs[2][31:0]), .y(ys[2][31:0]), .in_signed(sg[2]),
    .out_valid(pv[2]), .out_ready(outr[2]), .prod(p2));

  function automatic logic [127:0] prodof(input int d);
    case (d)
      0:       return p0;
      1:       return {96'd0, p1};
      default: return {64'd0, p2};
    endcase
  endfunction

  // Reference: sign-extend to 128 bits, multiply, keep 2*w bits.
  function automatic logic [127:0] refm(input logic [63:0] a, input logic [63:0] b,
                                        input logic s, input int w);
    logic [127:0] wm, ea, eb, pm;
    wm = (128'd1 << w) - 128'd1;
    ea = {64'd0, a} & wm;
    eb = {64'd0, b} & wm;
    if (s && ea[w-1]) ea = ea | ~wm;
    if (s && eb[w-1]) eb = eb | ~wm;
    pm = (128'd1 << (2*w)) - 128'd1;
    return (ea * eb) & pm;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_one(input int d, input string nm, input logic [63:0] a,
                        input logic [63:0] b, input logic s, input logic [127:0] e);
    @(negedge clk);
    xs[d] = a; ys[d] = b; sg[d] = s; outr[d] = 1'b1; inv[d] = 1'b1;
    chk({nm, "_in_ready"}, {127'd0, ir[d]}, 128'd1);
    @(posedge clk); #1;
    inv[d] = 1'b0; xs[d] = '1; ys[d] = '1; sg[d] = ~s;
    for (int c = 1; c <= LAT[d]; c++) begin
      @(posedge clk); #1;
      chk($sformatf("%s_valid_c%0d", nm, c), {127'd0, pv[d]}, {127'd0, (c == LAT[d])});
    end
    chk({nm, "_prod"}, prodof(d), e);
  endtask

  task automatic stream(input int d);
    int sent, got, cyc;
    logic held, stl;
    logic [127:0] hp;
    sent = 0; got = 0; cyc = 0; held = 1'b0; hp = '0;
    while (got < 8 && cyc < 200) begin
      @(posedge clk); #1;
      inv[d]  = (sent < 8);
      xs[d]   = 64'(sent);
      ys[d]   = 64'(sent + 1);
      sg[d]   = 1'b0;
      outr[d] = (cyc % 3 == 0);
      @(negedge clk);
      if (held) begin
        chk($sformatf("d%0d_stall_valid_hold", d), {127'd0, pv[d]}, 128'd1);
        chk($sformatf("d%0d_stall_prod_hold", d), prodof(d), hp);
      end
      stl = pv[d] & ~outr[d];
      chk($sformatf("d%0d_stream_in_ready_c%0d", d, cyc), {127'd0, ir[d]}, {127'd0, ~stl});
      if (pv[d] && outr[d]) begin
        chk($sformatf("d%0d_stream_prod_%0d", d, got), prodof(d), 128'(got * (got + 1)));
        got++;
      end
      held = stl;
      hp   = prodof(d);
      if (inv[d] && ir[d]) sent++;
      cyc++;
    end
    chk($sformatf("d%0d_stream_count", d), 128'(got), 128'd8);
    @(posedge clk); #1;
    inv[d] = 1'b0; outr[d] = 1'b1;
    for (int c = 0; c < LAT[d] + 2; c++) begin
      @(posedge clk); #1;
      chk($sformatf("d%0d_stream_no_extra_%0d", d, c), {127'd0, pv[d]}, 128'd0);
    end
  endtask

  initial begin
    tbl[0] = '{64'd10231, 64'd11231, 1'b0, 128'd114904361};
    tbl[1] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 1'b1,
               128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF1};
    tbl[2] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1,
               128'h4000_0000_0000_0000_0000_0000_0000_0000};
    tbl[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
               128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001};
    tbl[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 128'd1};
    tbl[5] = '{64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1,
               128'hC000_0000_0000_0000_8000_0000_0000_0000};
    tbl[6] = '{64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 1'b1, 128'd0};
    tbl[7] = '{64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF7, 1'b1, 128'd63};
    tbl[8] = '{64'h8000_0000_0000_0000, 64'd2, 1'b0, 128'h1_0000_0000_0000_0000};
    tbl[9] = '{64'h0000_0001_0000_0001, 64'h0000_0001_0000_0001, 1'b0,
               128'h1_0000_0002_0000_0001};

    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      inv[d] = 1'b0; outr[d] = 1'b1; sg[d] = 1'b0; xs[d] = '0; ys[d] = '0;
    end
    #2;
    chk("reset_out_valid", {127'd0, pv[0]}, 128'd0);
    chk("reset_prod", p0, 128'd0);
    chk("reset_in_ready", {127'd0, ir[0]}, 128'd1);
    #10 rst_n = 1'b1;

    for (int i = 0; i < NV; i++)
      do_one(0, $sformatf("d0_vec%0d", i), tbl[i].x, tbl[i].y, tbl[i].s, tbl[i].e);
    for (int d = 1; d < 3; d++)
      for (int i = 0; i < NV; i++)
        do_one(d, $sformatf("d%0d_vec%0d", d, i), tbl[i].x, tbl[i].y, tbl[i].s,
               refm(tbl[i].x, tbl[i].y, tbl[i].s, WID[d]));

    for (int d = 0; d < 3; d++) stream(d);

    // Three pairs in flight, then an asynchronous reset pulse between edges.
    @(negedge clk);
    inv[0] = 1'b1; outr[0] = 1'b1; sg[0] = 1'b0; xs[0] = 64'd3; ys[0] = 64'd4;
    @(posedge clk); #1; xs[0] = 64'd5; ys[0] = 64'd6;
    @(posedge clk); #1; xs[0] = 64'd7; ys[0] = 64'd8;
    @(posedge clk); #1; inv[0] = 1'b0;
    chk("pre_reset_prod_held", p0, 128'd56);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_out_valid", {127'd0, pv[0]}, 128'd0);
    chk("async_reset_prod", p0, 128'd0);
    chk("async_reset_in_ready", {127'd0, ir[0]}, 128'd1);
    @(posedge clk); #2 rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      chk($sformatf("post_reset_no_stale_%0d", c), {127'd0, pv[0]}, 128'd0);
    end
    do_one(0, "post_reset", 64'd7, 64'd6, 1'b0, 128'd42);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
